// File: rtl/demux64x1_8_buf.sv
// Buffered 1-to-8 demultiplexer: in-order FIFO of {sel, data} beats, head offered to one sink.
// Optional DEMUX_BEAT_COUNT_EN adds a free-running 32-bit count of delivered beats.
module demux64x1_8_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DEMUX_BEAT_COUNT_EN
    ,
    output logic [31:0]      beat_count
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [2:0]       sel_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic       empty;
    logic [2:0] head_sel;
    logic       push;
    logic       pop;

    // in_ready comes from registered state only; a full FIFO never takes a beat.
    assign in_ready = (count_q != FullCnt);
    assign empty    = (count_q == '0);
    assign head_sel = sel_mem[rd_ptr_q];
    assign push     = in_valid && in_ready;
    assign pop      = !empty && out_ready[head_sel];

    always_comb begin
        out_valid = 8'h00;
        out_data  = '0;
        if (!empty) begin
            out_valid = 8'h01 << head_sel;
            out_data  = data_mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            sel_mem[wr_ptr_q]  <= in_sel;
            data_mem[wr_ptr_q] <= in_data;
        end
    end

`ifdef DEMUX_BEAT_COUNT_EN
    logic [31:0] beat_count_q, beat_count_d;

    always_comb begin
        beat_count_d = beat_count_q;
        if (pop) beat_count_d = beat_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) beat_count_q <= 32'd0;
        else       beat_count_q <= beat_count_d;
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_demux64x1_8_buf.sv
// Randomized and directed bench for demux64x1_8_buf against a queue-based reference model.
module tb_demux64x1_8_buf;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_sel;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DEMUX_BEAT_COUNT_EN
    logic [31:0]      beat_count;
`endif

    always #5 clk = ~clk;

    demux64x1_8_buf #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_BEAT_COUNT_EN
        ,
        .beat_count(beat_count)
`endif
    );

    typedef struct {
        logic [2:0]       sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t       model_q[$];
    int unsigned model_pops;
    int unsigned vectors;
    int unsigned miscompares;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] d,
                         input logic [7:0] ordy, input logic rst);
        logic [7:0]       exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic             do_push;
        logic             do_pop;
        beat_t            nb;
        reset     = rst;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        exp_valid = 8'h00;
        exp_data  = '0;
        if (model_q.size() > 0) begin
            exp_valid = 8'h01 << model_q[0].sel;
            exp_data  = model_q[0].data;
        end
        check_eq("in_ready", {63'd0, in_ready}, {63'd0, model_q.size() != DEPTH});
        check_eq("out_valid", {56'd0, out_valid}, {56'd0, exp_valid});
        check_eq("out_data", out_data, exp_data);
`ifdef DEMUX_BEAT_COUNT_EN
        check_eq("beat_count", {32'd0, beat_count}, {32'd0, model_pops});
`endif
        do_push = v && (model_q.size() != DEPTH);
        do_pop  = (model_q.size() > 0) && ordy[model_q[0].sel];
        nb.sel  = s;
        nb.data = d;
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            model_pops = 0;
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                model_pops++;
            end
            if (do_push) model_q.push_back(nb);
        end
    endtask

    initial begin
        logic [7:0] rdy;
        vectors     = 0;
        miscompares = 0;
        model_pops  = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_sel      = 3'd0;
        in_data     = '0;
        out_ready   = 8'h00;
        @(posedge clk);
        #1;

        // Reset held two cycles with in_valid asserted.
        cycle(1'b1, 3'd1, 64'hDEAD, 8'hFF, 1'b1);
        cycle(1'b1, 3'd1, 64'hDEAD, 8'hFF, 1'b1);
        check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_valid", {56'd0, out_valid}, 64'd0);
        check_eq("rst_data", out_data, 64'd0);
        cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b0);
        check_eq("rst_empty", {56'd0, out_valid}, 64'd0);

        // Single beat.
        cycle(1'b1, 3'd3, 64'h5, 8'hFF, 1'b0);
        check_eq("single_valid", {56'd0, out_valid}, 64'h08);
        check_eq("single_data", out_data, 64'h5);
        cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b0);
        check_eq("single_gone", {56'd0, out_valid}, 64'h00);

        // Backpressure, full, and non-selected ready ignored.
        cycle(1'b1, 3'd0, 64'hA, 8'h00, 1'b0);
        cycle(1'b1, 3'd7, 64'hB, 8'h00, 1'b0);
        check_eq("full_ready", {63'd0, in_ready}, 64'd0);
        check_eq("full_valid", {56'd0, out_valid}, 64'h01);
        check_eq("full_data", out_data, 64'hA);
        cycle(1'b1, 3'd5, 64'hC, 8'h00, 1'b0);
        cycle(1'b1, 3'd5, 64'hC, 8'h80, 1'b0);
        check_eq("wrong_rdy_valid", {56'd0, out_valid}, 64'h01);
        check_eq("wrong_rdy_data", out_data, 64'hA);
        cycle(1'b1, 3'd5, 64'hC, 8'h01, 1'b0);
        check_eq("pop_valid", {56'd0, out_valid}, 64'h80);
        check_eq("pop_data", out_data, 64'hB);
        check_eq("pop_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b0);
        check_eq("drained", {56'd0, out_valid}, 64'h00);

        // Back-to-back sweep with simultaneous push/pop.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 64'(i), 8'hFF, 1'b0);
            check_eq("sweep_valid", {56'd0, out_valid}, 64'(8'h01 << i));
            check_eq("sweep_data", out_data, 64'(i));
            check_eq("sweep_ready", {63'd0, in_ready}, 64'd1);
        end
        cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b0);

        // Reset mid-operation discards queued beats.
        cycle(1'b1, 3'd2, 64'h11, 8'h00, 1'b0);
        cycle(1'b1, 3'd4, 64'h22, 8'h00, 1'b0);
        cycle(1'b1, 3'd6, 64'h33, 8'hFF, 1'b1);
        check_eq("midrst_valid", {56'd0, out_valid}, 64'h00);
        check_eq("midrst_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b0);
            check_eq("midrst_gone", {56'd0, out_valid}, 64'h00);
        end

`ifdef DEMUX_BEAT_COUNT_EN
        cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'($urandom_range(7)), 64'(i), 8'hFF, 1'b0);
        cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b0);
        check_eq("bc_ten", {32'd0, beat_count}, 64'd10);
        cycle(1'b0, 3'd0, 64'd0, 8'hFF, 1'b1);
        check_eq("bc_reset", {32'd0, beat_count}, 64'd0);
`endif

        // Randomized traffic with mixed backpressure and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(3))
                0:       rdy = 8'hFF;
                1:       rdy = 8'h00;
                default: rdy = 8'($urandom);
            endcase
            cycle($urandom_range(3) != 0, 3'($urandom_range(7)), {$urandom, $urandom}, rdy,
                  $urandom_range(199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
